// File: rtl/sdram_req_arbiter.sv
// Two-client request arbiter in front of an AXI-style SDRAM controller port.
// Holds one outstanding transaction; alternates grants when both clients ask.
//
// Ports:
//   clk, reset             single clock; asynchronous active-high reset
//   pN_req_valid/write     client N request (N=0,1); write=1, read=0
//   pN_req_addr/wdata      client N word address and write data
//   pN_req_ready           client N accepted this cycle (combinational)
//   pN_rsp_valid           one-cycle completion pulse to client N
//   pN_rsp_rdata/err       read data and timeout flag, held between pulses
//   m_axi_aw*/w*/ar*/r*    write address, write data, read address and
//                          read data channels to the SDRAM controller
//   busy                   high whenever the FSM is not idle
module sdram_req_arbiter #(
    parameter int ADDR_WIDTH     = 25,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  p0_req_valid,
    input  logic                  p0_req_write,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    output logic                  p0_req_ready,
    output logic                  p0_rsp_valid,
    output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
    output logic                  p0_rsp_err,

    input  logic                  p1_req_valid,
    input  logic                  p1_req_write,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    output logic                  p1_req_ready,
    output logic                  p1_rsp_valid,
    output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
    output logic                  p1_rsp_err,

    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic                  busy
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_WR,
        S_ISSUE_RD,
        S_WAIT_RD,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic                  prio_q, prio_d;
    logic                  id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  err0_q, err0_d;
    logic                  err1_q, err1_d;

    logic                  grant0, grant1;
    logic                  idle;
    logic                  aw_ok, w_ok;
    logic                  rsp_load;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    // prio_q == 0 favours client 0 on a tie
    assign grant0 = p0_req_valid & (~p1_req_valid | ~prio_q);
    assign grant1 = p1_req_valid & (~p0_req_valid |  prio_q);

    // reset gates ready directly so it drops before any clock edge
    assign idle         = (state_q == S_IDLE) & ~reset;
    assign p0_req_ready = idle & grant0;
    assign p1_req_ready = idle & grant1;

    // a channel is complete once seen before or handshaking now
    assign aw_ok = aw_done_q | m_axi_awready;
    assign w_ok  = w_done_q  | m_axi_wready;

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        id_d      = id_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        cnt_d     = cnt_q;
        rsp_load  = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (p0_req_ready | p1_req_ready) begin
                    id_d      = p1_req_ready;
                    prio_d    = ~p1_req_ready;
                    addr_d    = p1_req_ready ? p1_req_addr  : p0_req_addr;
                    wdata_d   = p1_req_ready ? p1_req_wdata : p0_req_wdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (p1_req_ready ? p1_req_write : p0_req_write)
                        state_d = S_ISSUE_WR;
                    else
                        state_d = S_ISSUE_RD;
                end
            end
            S_ISSUE_WR: begin
                aw_done_d = aw_ok;
                w_done_d  = w_ok;
                if (aw_ok & w_ok) begin
                    state_d  = S_RESP;
                    rsp_load = 1'b1;
                end
            end
            S_ISSUE_RD: begin
                if (m_axi_arready) begin
                    state_d = S_WAIT_RD;
                    cnt_d   = '0;
                end
            end
            S_WAIT_RD: begin
                cnt_d = cnt_q + 1'b1;
                if (m_axi_rvalid) begin
                    state_d   = S_RESP;
                    rsp_load  = 1'b1;
                    rsp_rdata = m_axi_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = S_RESP;
                    rsp_load = 1'b1;
                    rsp_err  = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // response fields are per client so each holds its own last result
    always_comb begin
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        err0_d   = err0_q;
        err1_d   = err1_q;
        if (rsp_load) begin
            if (id_q) begin
                rdata1_d = rsp_rdata;
                err1_d   = rsp_err;
            end else begin
                rdata0_d = rsp_rdata;
                err0_d   = rsp_err;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            prio_q    <= 1'b0;
            id_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            cnt_q     <= cnt_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
        end
    end

    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_awvalid = (state_q == S_ISSUE_WR) & ~aw_done_q;
    assign m_axi_wvalid  = (state_q == S_ISSUE_WR) & ~w_done_q;
    assign m_axi_arvalid = (state_q == S_ISSUE_RD);
    assign m_axi_rready  = (state_q == S_WAIT_RD);

    assign p0_rsp_valid  = (state_q == S_RESP) & ~id_q;
    assign p1_rsp_valid  = (state_q == S_RESP) &  id_q;
    assign p0_rsp_rdata  = rdata0_q;
    assign p1_rsp_rdata  = rdata1_q;
    assign p0_rsp_err    = err0_q;
    assign p1_rsp_err    = err1_q;

    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Self-checking bench for sdram_req_arbiter: vector table driven through
// an in-bench AXI slave, responses checked through a scoreboard queue.
module tb_sdram_req_arbiter;

    localparam int AW = 25;
    localparam int DW = 16;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          p0_req_valid, p0_req_write;
    logic [AW-1:0] p0_req_addr;
    logic [DW-1:0] p0_req_wdata;
    logic          p0_req_ready, p0_rsp_valid, p0_rsp_err;
    logic [DW-1:0] p0_rsp_rdata;
    logic          p1_req_valid, p1_req_write;
    logic [AW-1:0] p1_req_addr;
    logic [DW-1:0] p1_req_wdata;
    logic          p1_req_ready, p1_rsp_valid, p1_rsp_err;
    logic [DW-1:0] p1_rsp_rdata;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic          m_axi_awvalid, m_axi_awready;
    logic [DW-1:0] m_axi_wdata, m_axi_rdata;
    logic          m_axi_wvalid, m_axi_wready;
    logic          m_axi_arvalid, m_axi_arready;
    logic          m_axi_rvalid, m_axi_rready;
    logic          busy;

    sdram_req_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .p0_req_valid(p0_req_valid),
        .p0_req_write(p0_req_write),
        .p0_req_addr(p0_req_addr),
        .p0_req_wdata(p0_req_wdata),
        .p0_req_ready(p0_req_ready),
        .p0_rsp_valid(p0_rsp_valid),
        .p0_rsp_rdata(p0_rsp_rdata),
        .p0_rsp_err(p0_rsp_err),
        .p1_req_valid(p1_req_valid),
        .p1_req_write(p1_req_write),
        .p1_req_addr(p1_req_addr),
        .p1_req_wdata(p1_req_wdata),
        .p1_req_ready(p1_req_ready),
        .p1_rsp_valid(p1_rsp_valid),
        .p1_rsp_rdata(p1_rsp_rdata),
        .p1_rsp_err(p1_rsp_err),
        .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata),
        .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_araddr(m_axi_araddr),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata),
        .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          client;
        bit          other;
        bit          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int          awd;
        int          wd;
        int          ard;
        int          rd;
        logic [DW-1:0] rdata;
        logic [DW-1:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    typedef struct {
        bit          client;
        logic [DW-1:0] rdata;
        bit          err;
    } rsp_t;

    rsp_t sbq[$];
    rsp_t mon_e;
    bit   mon_c;
    logic [DW-1:0] mon_d;
    logic mon_r;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input bit cl, input bit v, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (cl) begin
            p1_req_valid = v;
            p1_req_write = wr;
            p1_req_addr  = a;
            p1_req_wdata = d;
        end else begin
            p0_req_valid = v;
            p0_req_write = wr;
            p0_req_addr  = a;
            p0_req_wdata = d;
        end
    endtask

    task automatic clear_req();
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && (p0_rsp_valid || p1_rsp_valid)) begin
            checks++;
            if (p0_rsp_valid && p1_rsp_valid) begin
                errors++;
                $display("FAIL rsp_both: got 11 want one-hot");
            end else if (sbq.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got pulse client %0d want none",
                         p1_rsp_valid);
            end else begin
                mon_e = sbq.pop_front();
                mon_c = p1_rsp_valid;
                mon_d = mon_c ? p1_rsp_rdata : p0_rsp_rdata;
                mon_r = mon_c ? p1_rsp_err : p0_rsp_err;
                if (mon_c != mon_e.client || mon_d !== mon_e.rdata ||
                    mon_r !== mon_e.err) begin
                    errors++;
                    $display("FAIL rsp_data: got c%0d d=%0h e=%0b want c%0d d=%0h e=%0b",
                             mon_c, mon_d, mon_r, mon_e.client,
                             mon_e.rdata, mon_e.err);
                end
            end
        end
    end

    task automatic run_txn(input vec_t v);
        int   n;
        int   last;
        rsp_t e;
        logic rdy, ordy;
        step();
        set_req(v.client, 1'b1, v.write, v.addr, v.wdata);
        if (v.other)
            set_req(~v.client, 1'b1, 1'b0, 25'h0F0F0F0, 16'h0);
        #2;
        chk("idle_busy", 32'(busy), 32'd0);
        n = 0;
        rdy = v.client ? p1_req_ready : p0_req_ready;
        while (!rdy && n < 4) begin
            step();
            #2;
            n++;
            rdy = v.client ? p1_req_ready : p0_req_ready;
        end
        chk("grant", 32'(rdy), 32'd1);
        ordy = v.client ? p0_req_ready : p1_req_ready;
        chk("grant_other", 32'(ordy), 32'd0);
        if (!rdy) begin
            clear_req();
            return;
        end
        e.client = v.client;
        e.rdata  = v.exp_rdata;
        e.err    = v.exp_err;
        sbq.push_back(e);
        step();
        set_req(v.client, 1'b0, v.write, v.addr, v.wdata);
        if (v.write) begin
            last = (v.awd > v.wd) ? v.awd : v.wd;
            for (int c = 0; c <= last; c++) begin
                if (c > 0) step();
                m_axi_awready = (c >= v.awd);
                m_axi_wready  = (c >= v.wd);
                #2;
                chk("awvalid", 32'(m_axi_awvalid), 32'(c <= v.awd));
                chk("wvalid", 32'(m_axi_wvalid), 32'(c <= v.wd));
                chk("awaddr", 32'(m_axi_awaddr), 32'(v.addr));
                chk("wdata", 32'(m_axi_wdata), 32'(v.wdata));
                chk("ready_busy", 32'(p0_req_ready | p1_req_ready), 32'd0);
            end
            step();
            m_axi_awready = 1'b0;
            m_axi_wready  = 1'b0;
        end else begin
            for (int c = 0; c <= v.ard; c++) begin
                if (c > 0) step();
                m_axi_arready = (c >= v.ard);
                #2;
                chk("arvalid", 32'(m_axi_arvalid), 32'd1);
                chk("araddr", 32'(m_axi_araddr), 32'(v.addr));
                chk("ready_busy", 32'(p0_req_ready | p1_req_ready), 32'd0);
            end
            step();
            m_axi_arready = 1'b0;
            for (int c = 0; c < TO; c++) begin
                if (c > 0) step();
                m_axi_rvalid = (c == v.rd);
                m_axi_rdata  = (c == v.rd) ? v.rdata : 16'hDEAD;
                #2;
                chk("rready", 32'(m_axi_rready), 32'd1);
                chk("arvalid_off", 32'(m_axi_arvalid), 32'd0);
                if (c == v.rd || c == TO - 1) break;
            end
            step();
            m_axi_rvalid = 1'b0;
            m_axi_rdata  = 16'hDEAD;
        end
        #2;
        chk("resp_pulse", 32'(v.client ? p1_rsp_valid : p0_rsp_valid), 32'd1);
        chk("resp_other", 32'(v.client ? p0_rsp_valid : p1_rsp_valid), 32'd0);
        chk("resp_rready", 32'(m_axi_rready), 32'd0);
        clear_req();
    endtask

    task automatic turnaround(input bit wr, input int gap);
        int   acc[$];
        rsp_t e;
        step();
        set_req(1'b0, 1'b1, wr, 25'h0000ABC, 16'h1111);
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        m_axi_arready = 1'b1;
        m_axi_rvalid  = 1'b1;
        m_axi_rdata   = 16'h7777;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) step();
            #2;
            if (p0_req_ready) begin
                acc.push_back(c);
                e.client = 1'b0;
                e.rdata  = wr ? 16'h0 : 16'h7777;
                e.err    = 1'b0;
                sbq.push_back(e);
            end
        end
        step();
        clear_req();
        repeat (6) step();
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        chk("turn_count", 32'(acc.size() >= 3), 32'd1);
        if (acc.size() >= 3) begin
            chk("turn_gap1", 32'(acc[1] - acc[0]), 32'(gap));
            chk("turn_gap2", 32'(acc[2] - acc[1]), 32'(gap));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b1, 25'h1ABCDEF, 16'hBEEF,
                    0, 3, 0, 0, 16'h0, 16'h0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 25'h0000123, 16'h0,
                    0, 0, 0, 2, 16'h5A5A, 16'h5A5A, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 25'h0000456, 16'h0,
                    0, 0, 2, 0, 16'h1234, 16'h1234, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 25'h1FFFFFF, 16'hFFFF,
                    2, 0, 0, 0, 16'h0, 16'h0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 25'h0AAAAAA, 16'h0,
                    0, 0, 0, -1, 16'h0, 16'h0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 25'h0555555, 16'h0,
                    0, 0, 0, 63, 16'hC3C3, 16'hC3C3, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 25'h0000000, 16'h0001,
                    1, 1, 0, 0, 16'h0, 16'h0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 25'h0012345, 16'h0,
                    0, 0, 1, 5, 16'h8001, 16'h8001, 1'b0};

        reset = 1'b1;
        set_req(1'b0, 1'b1, 1'b1, 25'h1, 16'h2);
        set_req(1'b1, 1'b0, 1'b0, 25'h0, 16'h0);
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = 16'hDEAD;
        #3;
        chk("rst_ready", 32'(p0_req_ready | p1_req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valids", 32'({m_axi_awvalid, m_axi_wvalid,
                               m_axi_arvalid, m_axi_rready}), 32'd0);
        chk("rst_addr", 32'(m_axi_awaddr | m_axi_araddr), 32'd0);
        chk("rst_wdata", 32'(m_axi_wdata), 32'd0);
        chk("rst_rsp", 32'({p0_rsp_valid, p1_rsp_valid, p0_rsp_err,
                            p1_rsp_err, p0_rsp_rdata, p1_rsp_rdata}), 32'd0);
        repeat (2) step();
        clear_req();
        reset = 1'b0;

        for (int i = 0; i < 8; i++)
            run_txn(vecs[i]);

        turnaround(1'b1, 3);
        turnaround(1'b0, 4);

        step();
        set_req(1'b0, 1'b1, 1'b0, 25'h0000789, 16'h0);
        m_axi_arready = 1'b1;
        #2;
        chk("mid_grant", 32'(p0_req_ready), 32'd1);
        step();
        clear_req();
        step();
        m_axi_arready = 1'b0;
        step();
        step();
        chk("mid_wait", 32'(m_axi_rready), 32'd1);
        set_req(1'b1, 1'b1, 1'b0, 25'h0000111, 16'h0);
        reset = 1'b1;
        #1;
        chk("mid_rready", 32'(m_axi_rready), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_ready", 32'(p0_req_ready | p1_req_ready), 32'd0);
        chk("mid_addr", 32'(m_axi_araddr), 32'd0);
        chk("mid_rsp", 32'({p0_rsp_valid, p1_rsp_valid, p0_rsp_err,
                            p1_rsp_err, p0_rsp_rdata, p1_rsp_rdata}), 32'd0);
        step();
        step();
        clear_req();
        reset = 1'b0;
        run_txn('{1'b1, 1'b0, 1'b0, 25'h0000321, 16'h0,
                  0, 0, 0, 1, 16'h4242, 16'h4242, 1'b0});

        repeat (3) step();
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
